// File: rtl/idli_fetch_m.sv
// idli_fetch_m: instruction fetch stage; buffers nibble-serial memory words and streams them LS slice first.
// Optional feature macro IDLI_FETCH_PREFETCH_EN: up to DEPTH words buffered or in flight (otherwise one).
module idli_fetch_m #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        i_if_gck,
    input  logic        i_if_rst_n,
    output logic [1:0]  o_if_ctr,
    output logic [3:0]  o_if_enc,
    output logic        o_if_enc_vld,
    input  logic        i_if_stall,
    input  logic        i_if_redir,
    input  logic [15:0] i_if_redir_pc,
    output logic        o_if_mem_req,
    output logic [15:0] o_if_mem_addr,
    input  logic        i_if_mem_ack,
    input  logic [3:0]  i_if_mem_data,
    input  logic        i_if_mem_vld
);

`ifdef IDLI_FETCH_PREFETCH_EN
    localparam int unsigned CAP = DEPTH;
`else
    localparam int unsigned CAP = 1;
`endif
    localparam int unsigned CW       = 3;
    localparam logic [CW-1:0] CAP_V  = CW'(CAP);
    localparam logic [1:0] LAST_PTR  = 2'(CAP - 1);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_depth_chk
            $error("idli_fetch_m: DEPTH must be in 1..4");
        end
    endgenerate

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST_PTR) ? 2'd0 : 2'(p + 2'd1);
    endfunction

    logic [1:0]    ctr_q;
    logic [15:0]   pc_q;
    logic [15:0]   fifo_q [4];
    logic [1:0]    head_q, tail_q;
    logic [CW-1:0] cnt_q, infl_q, drop_q;
    logic [11:0]   asm_q;
    logic [1:0]    sc_q;
    logic          armed_q, req_q, vld_q;
    logic [3:0]    enc_q;
    logic [15:0]   word_q;

    logic          ack, beat, last, drop_word, push, pop;
    logic [CW-1:0] cnt_n, infl_n, drop_n;
    logic [CW:0]   occ_n;
    logic [1:0]    head_n, tail_n, nxt_slice;
    logic [15:0]   pc_n, word_n, asm_word;
    logic          req_n, vld_n;
    logic [3:0]    enc_n;

    // Next-state: request/response bookkeeping, buffer pointers, issue and kill.
    always_comb begin
        ack       = i_if_mem_ack & req_q;
        beat      = i_if_mem_vld & armed_q;
        last      = beat & (sc_q == 2'd3);
        drop_word = last & (drop_q != '0);
        push      = last & ~drop_word;
        pop       = (ctr_q == 2'd3) & (cnt_q != '0) & ~i_if_stall & ~i_if_redir;
        asm_word  = {i_if_mem_data, asm_q};
        infl_n    = CW'(infl_q + CW'(ack) - CW'(last));
        cnt_n     = cnt_q;
        head_n    = head_q;
        tail_n    = tail_q;
        drop_n    = drop_q;
        pc_n      = pc_q;
        if (i_if_redir) begin
            // Everything still in flight, including a partial word, is stale.
            cnt_n  = '0;
            head_n = 2'd0;
            tail_n = 2'd0;
            drop_n = infl_n;
            pc_n   = i_if_redir_pc;
        end else begin
            cnt_n  = CW'(cnt_q + CW'(push) - CW'(pop));
            head_n = pop  ? ptr_inc(head_q) : head_q;
            tail_n = push ? ptr_inc(tail_q) : tail_q;
            drop_n = CW'(drop_q - CW'(drop_word));
            pc_n   = ack ? 16'(pc_q + 16'd1) : pc_q;
        end
        occ_n     = {1'b0, cnt_n} + {1'b0, infl_n};
        req_n     = occ_n < {1'b0, CAP_V};

        nxt_slice = 2'(ctr_q + 2'd1);
        word_n    = word_q;
        vld_n     = vld_q;
        enc_n     = 4'd0;
        if (i_if_redir) begin
            vld_n = 1'b0;
        end else if (ctr_q == 2'd3) begin
            vld_n  = pop;
            word_n = fifo_q[head_q];
            enc_n  = pop ? fifo_q[head_q][3:0] : 4'd0;
        end else if (vld_q) begin
            enc_n = word_q[{nxt_slice, 2'b00} +: 4];
        end
    end

    always_ff @(posedge i_if_gck) begin
        if (!i_if_rst_n) begin
            ctr_q   <= 2'd0;
            pc_q    <= RESET_PC;
            head_q  <= 2'd0;
            tail_q  <= 2'd0;
            cnt_q   <= '0;
            infl_q  <= '0;
            drop_q  <= '0;
            sc_q    <= 2'd0;
            armed_q <= 1'b0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
            enc_q   <= 4'd0;
        end else begin
            ctr_q   <= 2'(ctr_q + 2'd1);
            pc_q    <= pc_n;
            head_q  <= head_n;
            tail_q  <= tail_n;
            cnt_q   <= cnt_n;
            infl_q  <= infl_n;
            drop_q  <= drop_n;
            sc_q    <= beat ? 2'(sc_q + 2'd1) : sc_q;
            armed_q <= armed_q | ack;
            req_q   <= req_n;
            vld_q   <= vld_n;
            enc_q   <= enc_n;
        end
    end

    // Data-only storage; validity is tracked by the reset counters above.
    always_ff @(posedge i_if_gck) begin
        word_q <= word_n;
        if (push && !i_if_redir) begin
            fifo_q[tail_q] <= asm_word;
        end
        if (beat) begin
            case (sc_q)
                2'd0:    asm_q[3:0]  <= i_if_mem_data;
                2'd1:    asm_q[7:4]  <= i_if_mem_data;
                2'd2:    asm_q[11:8] <= i_if_mem_data;
                default: asm_q       <= asm_q;
            endcase
        end
    end

    assign o_if_ctr      = ctr_q;
    assign o_if_enc      = enc_q;
    assign o_if_enc_vld  = vld_q;
    assign o_if_mem_req  = req_q;
    assign o_if_mem_addr = pc_q;

endmodule

// File: tb/tb_idli_fetch_m.sv
// Directed bench for idli_fetch_m: in-order nibble memory model, issue monitor, scenario tasks.
module tb_idli_fetch_m;
`ifdef IDLI_FETCH_PREFETCH_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ctr;
    logic [3:0]  enc;
    logic        vld;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [15:0] redir_pc = 16'h0000;
    logic        req;
    logic [15:0] addr;
    logic        ack = 1'b0;
    logic [3:0]  mdata = 4'h0;
    logic        mvld = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    idli_fetch_m #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
        .i_if_gck(clk), .i_if_rst_n(rst_n), .o_if_ctr(ctr), .o_if_enc(enc),
        .o_if_enc_vld(vld), .i_if_stall(stall), .i_if_redir(redir),
        .i_if_redir_pc(redir_pc), .o_if_mem_req(req), .o_if_mem_addr(addr),
        .i_if_mem_ack(ack), .i_if_mem_data(mdata), .i_if_mem_vld(mvld)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'(a + 16'h4321);
    endfunction

    // Memory model: immediate ack, in-order responses starting the cycle after ack.
    logic [15:0] aq [$];
    logic [15:0] ack_log [$];
    logic        ack_en = 1'b0;
    logic        busy = 1'b0;
    int          sl = 0;
    logic [15:0] cur = 16'h0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) aq.delete();
        if (!busy && aq.size() > 0) begin
            cur  = mem_word(aq.pop_front());
            busy = 1'b1;
            sl   = 0;
        end
        if (busy) begin
            mvld  = 1'b1;
            mdata = cur[4*sl +: 4];
            sl++;
            if (sl == 4) busy = 1'b0;
        end else begin
            mvld  = 1'b0;
            mdata = 4'h0;
        end
        ack = ack_en && req;
        if (ack) begin
            aq.push_back(addr);
            ack_log.push_back(addr);
        end
    end

    // Issue monitor: rebuilds each window's word and valid mask.
    logic [15:0] iss_q [$];
    logic [3:0]  iss_m [$];
    int          iss_w [$];
    int          win = 0;
    int          bad_zero = 0;
    logic [15:0] wbuf = 16'h0;
    logic [3:0]  mask = 4'h0;
    initial forever begin
        @(negedge clk);
        if (!vld && enc != 4'h0) bad_zero++;
        if (!rst_n) begin
            wbuf = 16'h0;
            mask = 4'h0;
        end else begin
            wbuf[4*ctr +: 4] = enc;
            mask[ctr] = vld;
            if (ctr == 2'd3) begin
                if (mask != 4'h0) begin
                    iss_q.push_back(wbuf);
                    iss_m.push_back(mask);
                    iss_w.push_back(win);
                end
                win++;
                wbuf = 16'h0;
                mask = 4'h0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_issued();
        iss_q.delete();
        iss_m.delete();
        iss_w.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ack_en = 1'b0;
        repeat (3) tick();
        n_tests++; if (ctr !== 2'd0) begin n_fail++; $display("FAIL reset_ctr: got %0d expected 0", ctr); end
        n_tests++; if (enc !== 4'h0) begin n_fail++; $display("FAIL reset_enc: got %h expected 0", enc); end
        n_tests++; if (vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", vld); end
        n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", req); end
    endtask

    task automatic test_first_fetch();
        ack_en = 1'b1;
        rst_n = 1'b1;
        tick();
        n_tests++; if (ctr !== 2'd1) begin n_fail++; $display("FAIL first_ctr: got %0d expected 1", ctr); end
        n_tests++; if (req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b expected 1", req); end
        n_tests++; if (addr !== 16'h0000) begin n_fail++; $display("FAIL first_addr: got %h expected 0000", addr); end
        for (int i = 0; i < 80 && iss_q.size() < 1; i++) tick();
        n_tests++;
        if (iss_q.size() < 1) begin
            n_fail++; $display("FAIL first_timeout: got 0 words expected 1");
        end else begin
            if (iss_q[0] !== 16'h4321) begin n_fail++; $display("FAIL first_word: got %h expected 4321", iss_q[0]); end
            n_tests++; if (iss_m[0] !== 4'hF) begin n_fail++; $display("FAIL first_mask: got %h expected f", iss_m[0]); end
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 300 && iss_q.size() < 5; i++) tick();
        n_tests++;
        if (iss_q.size() < 5) begin
            n_fail++; $display("FAIL stream_timeout: got %0d words expected 5", iss_q.size());
        end else begin
            for (int k = 1; k < 5; k++) begin
                n_tests++;
                if (iss_q[k] !== mem_word(16'(k)) || iss_m[k] !== 4'hF)
                    begin n_fail++; $display("FAIL stream_word%0d: got %h/%h expected %h/f", k, iss_q[k], iss_m[k], mem_word(16'(k))); end
            end
        end
    endtask

    task automatic test_stall();
        int n0, bad, w0;
        stall = 1'b1;
        repeat (48) tick();
        n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL stall_req_full: got %b expected 0", req); end
        n0 = iss_q.size();
        bad = 0;
        repeat (8) begin tick(); if (vld) bad++; end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL stall_vld: got %0d valid cycles expected 0", bad); end
        n_tests++; if (iss_q.size() != n0) begin n_fail++; $display("FAIL stall_nopop: got %0d words expected %0d", iss_q.size(), n0); end
        for (int i = 0; i < 4 && ctr != 2'd0; i++) tick();
        stall = 1'b0;
        w0 = win;
        for (int i = 0; i < 60 && iss_q.size() < n0 + CAP; i++) tick();
        n_tests++;
        if (iss_q.size() < n0 + CAP) begin
            n_fail++; $display("FAIL stall_release_timeout: got %0d words expected %0d", iss_q.size(), n0 + CAP);
        end else begin
            if (iss_w[n0] != w0 + 1) begin n_fail++; $display("FAIL stall_first_window: got %0d expected %0d", iss_w[n0], w0 + 1); end
            for (int k = 0; k < CAP; k++) begin
                n_tests++;
                if (iss_q[n0+k] !== mem_word(16'(n0 + k)))
                    begin n_fail++; $display("FAIL stall_order%0d: got %h expected %h", k, iss_q[n0+k], mem_word(16'(n0 + k))); end
            end
            for (int k = 1; k < CAP; k++) begin
                n_tests++;
                if (iss_w[n0+k] != w0 + 1 + k)
                    begin n_fail++; $display("FAIL stall_consecutive%0d: got %0d expected %0d", k, iss_w[n0+k], w0 + 1 + k); end
            end
        end
    endtask

    task automatic test_redirect();
        int mark;
        for (int i = 0; i < 200 && !(ctr == 2'd1 && vld && busy); i++) tick();
        n_tests++; if (!(ctr == 2'd1 && vld && busy)) begin n_fail++; $display("FAIL redir_setup: got ctr %0d vld %b expected streaming with partial word", ctr, vld); end
        redir = 1'b1;
        redir_pc = 16'h1234;
        @(posedge clk);
        mark = ack_log.size();
        tick();
        redir = 1'b0;
        n_tests++; if (vld !== 1'b0 || enc !== 4'h0) begin n_fail++; $display("FAIL redir_kill_ctr2: got vld %b enc %h expected 0/0", vld, enc); end
        n_tests++; if (addr !== 16'h1234) begin n_fail++; $display("FAIL redir_addr: got %h expected 1234", addr); end
        tick();
        n_tests++; if (vld !== 1'b0) begin n_fail++; $display("FAIL redir_kill_ctr3: got %b expected 0", vld); end
        for (int i = 0; i < 4 && ctr != 2'd0; i++) tick();
        clear_issued();
        for (int i = 0; i < 200 && iss_q.size() < 2; i++) tick();
        n_tests++;
        if (iss_q.size() < 2) begin
            n_fail++; $display("FAIL redir_timeout: got %0d words expected 2", iss_q.size());
        end else begin
            if (iss_q[0] !== 16'h5555) begin n_fail++; $display("FAIL redir_word0: got %h expected 5555", iss_q[0]); end
            n_tests++; if (iss_q[1] !== 16'h5556) begin n_fail++; $display("FAIL redir_word1: got %h expected 5556", iss_q[1]); end
            n_tests++; if (ack_log[mark] !== 16'h1234) begin n_fail++; $display("FAIL redir_req_addr: got %h expected 1234", ack_log[mark]); end
        end
    endtask

    task automatic test_pc_wrap();
        int mark;
        redir = 1'b1;
        redir_pc = 16'hFFFF;
        @(posedge clk);
        mark = ack_log.size();
        tick();
        redir = 1'b0;
        n_tests++; if (addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_addr: got %h expected ffff", addr); end
        for (int i = 0; i < 4 && ctr != 2'd0; i++) tick();
        clear_issued();
        for (int i = 0; i < 200 && iss_q.size() < 2; i++) tick();
        n_tests++;
        if (iss_q.size() < 2 || ack_log.size() < mark + 2) begin
            n_fail++; $display("FAIL wrap_timeout: got %0d words expected 2", iss_q.size());
        end else begin
            if (iss_q[0] !== 16'h4320) begin n_fail++; $display("FAIL wrap_word0: got %h expected 4320", iss_q[0]); end
            n_tests++; if (iss_q[1] !== 16'h4321) begin n_fail++; $display("FAIL wrap_word1: got %h expected 4321", iss_q[1]); end
            n_tests++; if (ack_log[mark+1] !== 16'h0000) begin n_fail++; $display("FAIL wrap_next_addr: got %h expected 0000", ack_log[mark+1]); end
        end
    endtask

    task automatic test_redir_ack();
        int mark;
        for (int i = 0; i < 200 && !(req && ack); i++) tick();
        n_tests++; if (!(req && ack)) begin n_fail++; $display("FAIL redack_setup: got req %b ack %b expected 1/1", req, ack); end
        redir = 1'b1;
        redir_pc = 16'h0ABC;
        @(posedge clk);
        mark = ack_log.size();
        tick();
        redir = 1'b0;
        n_tests++; if (addr !== 16'h0ABC) begin n_fail++; $display("FAIL redack_pc: got %h expected 0abc", addr); end
        for (int i = 0; i < 4 && ctr != 2'd0; i++) tick();
        clear_issued();
        for (int i = 0; i < 200 && iss_q.size() < 2; i++) tick();
        n_tests++;
        if (iss_q.size() < 2) begin
            n_fail++; $display("FAIL redack_timeout: got %0d words expected 2", iss_q.size());
        end else begin
            if (iss_q[0] !== 16'h4DDD) begin n_fail++; $display("FAIL redack_word0: got %h expected 4ddd", iss_q[0]); end
            n_tests++; if (iss_q[1] !== 16'h4DDE) begin n_fail++; $display("FAIL redack_word1: got %h expected 4dde", iss_q[1]); end
            n_tests++; if (ack_log[mark] !== 16'h0ABC) begin n_fail++; $display("FAIL redack_req_addr: got %h expected 0abc", ack_log[mark]); end
        end
    endtask

    task automatic test_reset_mid();
        int mark;
        for (int i = 0; i < 200 && !(busy && sl == 1); i++) tick();
        n_tests++; if (!(busy && sl == 1)) begin n_fail++; $display("FAIL rstmid_setup: got slice %0d expected 1", sl); end
        rst_n = 1'b0;
        ack_en = 1'b0;
        tick();
        n_tests++; if (ctr !== 2'd0 || enc !== 4'h0 || vld !== 1'b0 || req !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_outputs: got ctr %0d enc %h vld %b req %b expected all 0", ctr, enc, vld, req); end
        rst_n = 1'b1;
        clear_issued();
        mark = ack_log.size();
        repeat (6) tick();
        n_tests++; if (req !== 1'b1 || addr !== 16'h0000) begin n_fail++; $display("FAIL rstmid_req: got req %b addr %h expected 1/0000", req, addr); end
        ack_en = 1'b1;
        for (int i = 0; i < 200 && iss_q.size() < 2; i++) tick();
        n_tests++;
        if (iss_q.size() < 2) begin
            n_fail++; $display("FAIL rstmid_timeout: got %0d words expected 2", iss_q.size());
        end else begin
            if (iss_q[0] !== 16'h4321) begin n_fail++; $display("FAIL rstmid_word0: got %h expected 4321", iss_q[0]); end
            n_tests++; if (iss_q[1] !== 16'h4322) begin n_fail++; $display("FAIL rstmid_word1: got %h expected 4322", iss_q[1]); end
            n_tests++; if (ack_log[mark] !== 16'h0000) begin n_fail++; $display("FAIL rstmid_req_addr: got %h expected 0000", ack_log[mark]); end
        end
    endtask

    task automatic test_invariants();
        n_tests++; if (bad_zero != 0) begin n_fail++; $display("FAIL enc_zero_when_invalid: got %0d cycles expected 0", bad_zero); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stream();
        test_stall();
        test_redirect();
        test_pc_wrap();
        test_redir_ack();
        test_reset_mid();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
